// File: rtl/rs_asm_randomizer.sv
// Sync-marker inserter and CCSDS randomizer placed after rs_encoder.
// Each codeword is preceded by the 4-byte ASM_WORD (MSB byte first). Codeword
// bytes are optionally XORed with the CCSDS pseudo-random sequence. The LFSR
// is reseeded at the start of every codeword. The output stage is a single
// register with a valid/ready handshake.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_axis_valid/ready/data       input codeword byte stream
//   s_axis_sop/last/is_parity     input framing flags (checked only) and parity tag
//   m_axis_valid/ready/data       output byte stream (ASM + codeword)
//   m_axis_sop/last/is_asm        output framing flags, derived from internal counters
//   m_axis_is_parity              registered parity tag, 0 during ASM
//   frame_err                     sticky input framing error
module rs_asm_randomizer #(
  parameter int unsigned CW_LEN   = 255,
  parameter logic [31:0] ASM_WORD = 32'h1ACF_FC1D,
  parameter bit          RAND_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_axis_valid,
  output logic       s_axis_ready,
  input  logic [7:0] s_axis_data,
  input  logic       s_axis_last,
  input  logic       s_axis_sop,
  input  logic       s_axis_is_parity,
  output logic       m_axis_valid,
  input  logic       m_axis_ready,
  output logic [7:0] m_axis_data,
  output logic       m_axis_last,
  output logic       m_axis_sop,
  output logic       m_axis_is_asm,
  output logic       m_axis_is_parity,
  output logic       frame_err
);

  localparam int unsigned    CNT_W     = (CW_LEN > 1) ? $clog2(CW_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW_LEN - 1);
  localparam logic [7:0]     LFSR_SEED = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ASM  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         asm_cnt_q, asm_cnt_d;
  logic [CNT_W-1:0]   body_cnt_q, body_cnt_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               valid_d, sop_d, last_d, is_asm_d, is_par_d, err_d;
  logic [7:0]         data_d;
  logic [7:0]         asm_byte;
  logic               stage_free;
  logic               s_hs;
  logic               body_last;

  // Advance the randomizer window by 8 bits. The window holds the next 8
  // sequence bits, oldest in bit 7, so the window itself is the rand byte.
  // Recurrence from x^8+x^7+x^5+x^3+1: a[n+8] = a[n+7]^a[n+5]^a[n+3]^a[n].
  function automatic logic [7:0] lfsr_next8(input logic [7:0] s);
    logic [7:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[6:0], t[7] ^ t[4] ^ t[2] ^ t[0]};
    end
    return t;
  endfunction

  assign stage_free   = !m_axis_valid || m_axis_ready;
  assign s_axis_ready = (state_q == ST_BODY) && stage_free;
  assign s_hs         = s_axis_valid && s_axis_ready;
  assign body_last    = (body_cnt_q == LAST_CNT);

  // ASM byte select, MSB byte first
  always_comb begin
    asm_byte = ASM_WORD[31:24];
    case (asm_cnt_q)
      2'd0:    asm_byte = ASM_WORD[31:24];
      2'd1:    asm_byte = ASM_WORD[23:16];
      2'd2:    asm_byte = ASM_WORD[15:8];
      default: asm_byte = ASM_WORD[7:0];
    endcase
  end

  // Next-state, counters, LFSR and output-stage load
  always_comb begin
    state_d    = state_q;
    asm_cnt_d  = asm_cnt_q;
    body_cnt_d = body_cnt_q;
    lfsr_d     = lfsr_q;
    valid_d    = m_axis_valid;
    data_d     = m_axis_data;
    sop_d      = m_axis_sop;
    last_d     = m_axis_last;
    is_asm_d   = m_axis_is_asm;
    is_par_d   = m_axis_is_parity;
    err_d      = frame_err;

    // a held byte leaves the stage when accepted; reloaded below if needed
    if (stage_free) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (stage_free && s_axis_valid) begin
          state_d   = ST_ASM;
          asm_cnt_d = 2'd0;
        end
      end
      ST_ASM: begin
        if (stage_free) begin
          valid_d  = 1'b1;
          data_d   = asm_byte;
          sop_d    = (asm_cnt_q == 2'd0);
          last_d   = 1'b0;
          is_asm_d = 1'b1;
          is_par_d = 1'b0;
          if (asm_cnt_q == 2'd3) begin
            state_d    = ST_BODY;
            asm_cnt_d  = 2'd0;
            body_cnt_d = '0;
            lfsr_d     = LFSR_SEED;
          end else begin
            asm_cnt_d = asm_cnt_q + 2'd1;
          end
        end
      end
      ST_BODY: begin
        if (s_hs) begin
          valid_d  = 1'b1;
          data_d   = RAND_EN ? (s_axis_data ^ lfsr_q) : s_axis_data;
          sop_d    = 1'b0;
          last_d   = body_last;
          is_asm_d = 1'b0;
          is_par_d = s_axis_is_parity;
          lfsr_d   = lfsr_next8(lfsr_q);
          // input flags are only checked; framing follows body_cnt
          if ((s_axis_sop != (body_cnt_q == '0)) || (s_axis_last != body_last)) begin
            err_d = 1'b1;
          end
          if (body_last) begin
            state_d    = ST_IDLE;
            body_cnt_d = '0;
          end else begin
            body_cnt_d = body_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      asm_cnt_q        <= 2'd0;
      body_cnt_q       <= '0;
      lfsr_q           <= LFSR_SEED;
      m_axis_valid     <= 1'b0;
      m_axis_data      <= 8'h00;
      m_axis_sop       <= 1'b0;
      m_axis_last      <= 1'b0;
      m_axis_is_asm    <= 1'b0;
      m_axis_is_parity <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      state_q          <= state_d;
      asm_cnt_q        <= asm_cnt_d;
      body_cnt_q       <= body_cnt_d;
      lfsr_q           <= lfsr_d;
      m_axis_valid     <= valid_d;
      m_axis_data      <= data_d;
      m_axis_sop       <= sop_d;
      m_axis_last      <= last_d;
      m_axis_is_asm    <= is_asm_d;
      m_axis_is_parity <= is_par_d;
      frame_err        <= err_d;
    end
  end

endmodule

// File: tb/tb_rs_asm_randomizer.sv
// Scoreboard bench for rs_asm_randomizer: one instance with the randomizer
// enabled and one in pass-through, both fed the same stimulus.
module tb_rs_asm_randomizer;

  localparam int CW = 255;
  localparam int K  = 223;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       last;
    logic       asm_f;
    logic       par;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_last, s_sop, s_par;
  logic [7:0] s_data;
  logic       m_ready = 1'b1;
  logic       ready_r, ready_p;
  logic       v_r, v_p, l_r, l_p, sp_r, sp_p, a_r, a_p, p_r, p_p, err_r, err_p;
  logic [7:0] d_r, d_p;

  int    checks = 0;
  int    errors = 0;
  item_t q_r[$];
  item_t q_p[$];
  int    pushed = 0;
  int    popped[2];
  logic  hold[2];
  item_t held[2];
  logic  exp_err = 1'b0;
  logic  stall_en = 1'b0;
  logic [31:0] st_lfsr = 32'h1ACEB00C;
  logic [7:0]  rand_seq[CW];
  logic [7:0]  asm_b[4];

  always #5 clk = ~clk;

  rs_asm_randomizer #(.CW_LEN(CW), .ASM_WORD(32'h1ACF_FC1D), .RAND_EN(1'b1)) u_r (
    .clk(clk), .rst_n(rst_n),
    .s_axis_valid(s_valid), .s_axis_ready(ready_r), .s_axis_data(s_data),
    .s_axis_last(s_last), .s_axis_sop(s_sop), .s_axis_is_parity(s_par),
    .m_axis_valid(v_r), .m_axis_ready(m_ready), .m_axis_data(d_r),
    .m_axis_last(l_r), .m_axis_sop(sp_r), .m_axis_is_asm(a_r),
    .m_axis_is_parity(p_r), .frame_err(err_r));

  rs_asm_randomizer #(.CW_LEN(CW), .ASM_WORD(32'h1ACF_FC1D), .RAND_EN(1'b0)) u_p (
    .clk(clk), .rst_n(rst_n),
    .s_axis_valid(s_valid), .s_axis_ready(ready_p), .s_axis_data(s_data),
    .s_axis_last(s_last), .s_axis_sop(s_sop), .s_axis_is_parity(s_par),
    .m_axis_valid(v_p), .m_axis_ready(m_ready), .m_axis_data(d_p),
    .m_axis_last(l_p), .m_axis_sop(sp_p), .m_axis_is_asm(a_p),
    .m_axis_is_parity(p_p), .frame_err(err_p));

  // Downstream ready: always 1, or ~87% duty from a 32-bit LFSR
  always @(posedge clk) begin
    #1;
    if (stall_en) begin
      st_lfsr = {st_lfsr[30:0], st_lfsr[31] ^ st_lfsr[21] ^ st_lfsr[1] ^ st_lfsr[0]};
      m_ready = (st_lfsr[2:0] != 3'b000);
    end else begin
      m_ready = 1'b1;
    end
  end

  task automatic score(input int w, input logic v, input item_t got);
    item_t e;
    logic  empty;
    if (hold[w]) begin
      checks++;
      if (!v || got !== held[w]) begin
        errors++;
        $display("FAIL stable[%0d] got v=%0b %h required v=1 %h", w, v, got, held[w]);
      end
    end
    hold[w] = v && !m_ready;
    held[w] = got;
    if (v && m_ready) begin
      checks++;
      empty = (w == 0) ? (q_r.size() == 0) : (q_p.size() == 0);
      if (empty) begin
        errors++;
        $display("FAIL unexpected[%0d] got %h required nothing", w, got);
      end else begin
        e = (w == 0) ? q_r.pop_front() : q_p.pop_front();
        popped[w]++;
        if (got !== e) begin
          errors++;
          $display("FAIL byte[%0d] #%0d got %h required %h", w, popped[w] - 1, got, e);
        end
      end
    end
  endtask

  // Monitor: a byte is taken when valid & ready just before the rising edge
  always @(negedge clk) begin
    item_t g0, g1;
    if (!rst_n) begin
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      g0.data = d_r; g0.sop = sp_r; g0.last = l_r; g0.asm_f = a_r; g0.par = p_r;
      g1.data = d_p; g1.sop = sp_p; g1.last = l_p; g1.asm_f = a_p; g1.par = p_p;
      score(0, v_r, g0);
      score(1, v_p, g1);
    end
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic chk_clear(input string name);
    chk({name, "_r"}, int'({v_r, d_r, l_r, sp_r, a_r, p_r, err_r, ready_r}), 0);
    chk({name, "_p"}, int'({v_p, d_p, l_p, sp_p, a_p, p_p, err_p, ready_p}), 0);
  endtask

  task automatic wait_hs(output bit ok);
    bit hs;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      hs = ready_r;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        return;
      end
    end
    errors++;
    $display("FAIL handshake_timeout got no s_axis_ready required handshake");
  endtask

  // kind 0: zero bytes, 1: random bytes
  task automatic send_frame(input int kind, input int early_last, input int reset_at);
    item_t e;
    bit    ok;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      e.data = asm_b[k]; e.sop = (k == 0); e.last = 1'b0; e.asm_f = 1'b1; e.par = 1'b0;
      q_r.push_back(e);
      q_p.push_back(e);
      pushed++;
    end
    for (int i = 0; i < CW; i++) begin
      d = (kind == 0) ? 8'h00 : 8'($urandom);
      s_data  = d;
      s_sop   = (i == 0);
      s_last  = (i == CW - 1) || (i == early_last);
      s_par   = (i >= K);
      s_valid = 1'b1;
      wait_hs(ok);
      if (!ok) return;
      e.sop = 1'b0; e.last = (i == CW - 1); e.asm_f = 1'b0; e.par = (i >= K);
      e.data = d ^ rand_seq[i];
      q_r.push_back(e);
      e.data = d;
      q_p.push_back(e);
      pushed++;
      if (i == early_last) exp_err = 1'b1;
      if (early_last >= 0 && (i == early_last - 1 || i == early_last)) begin
        chk("frame_err_early_r", int'(err_r), int'(exp_err));
        chk("frame_err_early_p", int'(err_p), int'(exp_err));
      end
      if (i == reset_at) begin
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk_clear("async_reset");
        q_r.delete();
        q_p.delete();
        popped[0] = 0;
        popped[1] = 0;
        pushed    = 0;
        exp_err   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("frame_err_end_r", int'(err_r), int'(exp_err));
    chk("frame_err_end_p", int'(err_p), int'(exp_err));
  endtask

  initial begin
    int bits[CW * 8];
    bit done;
    // CCSDS sequence from its recurrence, seed all ones
    for (int n = 0; n < CW * 8; n++) begin
      if (n < 8) bits[n] = 1;
      else bits[n] = bits[n-1] ^ bits[n-3] ^ bits[n-5] ^ bits[n-8];
    end
    for (int b = 0; b < CW; b++) begin
      rand_seq[b] = 8'h00;
      for (int j = 0; j < 8; j++) rand_seq[b] = {rand_seq[b][6:0], 1'(bits[8*b + j])};
    end
    asm_b[0] = 8'h1A; asm_b[1] = 8'hCF; asm_b[2] = 8'hFC; asm_b[3] = 8'h1D;
    popped[0] = 0; popped[1] = 0;
    hold[0] = 1'b0; hold[1] = 1'b0;

    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_sop = 1'b0; s_par = 1'b0;
    #23;
    chk_clear("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_frame(0, -1, -1);
    send_frame(1, -1, -1);
    send_frame(1, -1, -1);
    stall_en = 1'b1;
    send_frame(1, -1, -1);
    send_frame(1, -1, -1);
    send_frame(0, -1, -1);
    send_frame(1, 100, -1);
    send_frame(1, -1, 50);
    send_frame(0, -1, -1);
    s_valid = 1'b0;

    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk);
      done = (q_r.size() == 0) && (q_p.size() == 0);
    end
    #1;
    chk("drain_r", q_r.size(), 0);
    chk("drain_p", q_p.size(), 0);
    chk("count_r", popped[0], pushed);
    chk("count_p", popped[1], pushed);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid", int'({v_r, v_p}), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_asm_randomizer.md
Name: rs_asm_randomizer

Overview:
- Downstream neighbour of rs_encoder; consumes its codeword byte stream (data, sop, last, is_parity).
- Prefixes every codeword with a 4-byte attached sync marker (ASM) 0x1ACFFC1D.
- Optionally XORs codeword bytes with the CCSDS pseudo-randomizer sequence; the ASM bytes are never randomized.
- Output feeds the downstream framer/serializer as a byte stream with a registered handshake.

Parameters:
- CW_LEN, 255, codeword bytes per frame (RS_K + RS_PARITY_BYTES).
- ASM_WORD, 32'h1ACF_FC1D, sync marker, sent MSB byte first.
- RAND_EN, 1, 1 = apply randomizer to codeword bytes; 0 = pass-through.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_valid  in  1  input byte valid
- s_axis_ready  out  1  input byte accepted when valid&ready
- s_axis_data  in  8  codeword byte
- s_axis_last  in  1  last codeword byte
- s_axis_sop  in  1  first codeword byte
- s_axis_is_parity  in  1  byte is RS parity
- m_axis_valid  out  1  output byte valid
- m_axis_ready  in  1  downstream ready
- m_axis_data  out  8  ASM or (randomized) codeword byte
- m_axis_last  out  1  last byte of frame (codeword byte CW_LEN-1)
- m_axis_sop  out  1  first ASM byte of frame
- m_axis_is_asm  out  1  byte is ASM
- m_axis_is_parity  out  1  registered copy of s_axis_is_parity; 0 during ASM
- frame_err  out  1  sticky framing error, cleared only by reset

Behaviour:
- Reset (async on rst_n low): all m_axis_* = 0, s_axis_ready = 0, frame_err = 0, FSM = IDLE, counters = 0, LFSR = 8'hFF.
- Output stage: single register. It loads when `!m_axis_valid || m_axis_ready`, so it is "free".
- m_axis_valid stays high, with data, flags and stable data, until accepted.
- FSM states:
  - IDLE: s_axis_ready = 0. If s_axis_valid is seen, go to ASM with asm_cnt = 0. No input byte is consumed.
  - ASM: each cycle the stage is free, load ASM byte asm_cnt (0 = 0x1A, 1 = 0xCF, 2 = 0xFC, 3 = 0x1D).
    - Flags: is_asm = 1; sop = (asm_cnt == 0); last = 0; is_parity = 0.
    - After loading byte 3, go to BODY with body_cnt = 0 and LFSR = 8'hFF.
  - BODY: s_axis_ready = stage free. On a handshake, load data XOR rand_byte (or raw data if RAND_EN = 0).
    - Flags: is_asm = 0; sop = 0; last = (body_cnt == CW_LEN-1); is_parity = s_axis_is_parity.
    - Increment body_cnt and advance the LFSR by 8 bits.
    - At body_cnt == CW_LEN-1, go to IDLE.
- Randomizer: CCSDS polynomial x^8+x^7+x^5+x^3+1, seed all ones, reseeded at every codeword start.
  - rand_byte is 8 successive LFSR output bits, MSB first.
  - Sequence starts FF 48 0E C0 9A 0D 70 BC.
- Framing authority is body_cnt; input flags are checked only. frame_err is set on any of:
  - a handshaken byte with s_axis_sop != (body_cnt == 0);
  - a handshaken byte with s_axis_last != (body_cnt == CW_LEN-1).
  - Data still passes through unchanged; m_axis_last follows the count, not the input flag.
- Latency: first ASM byte is valid 1 cycle after IDLE samples s_axis_valid. Each codeword byte is valid 1 cycle after its handshake.
- Throughput: with m_axis_ready held at 1, a frame is CW_LEN+4 consecutive output cycles. The next ASM follows immediately if s_axis_valid is held.
- Back-to-back: IDLE→ASM costs 1 bubble cycle per frame, which is acceptable.
- Backpressure: m_axis_ready = 0 freezes FSM, counters, LFSR and output register. s_axis_ready drops in the same cycle.
- s_axis_ready never depends combinationally on s_axis_valid.
- Reset mid-frame: everything returns to reset values immediately. The next frame starts with a fresh ASM and LFSR seed.

Test Plan:
- Single codeword of 255 zero bytes, RAND_EN = 1, m_axis_ready = 1:
  - output 1A CF FC 1D then FF 48 0E C0 9A 0D 70 BC …
  - 259 bytes total; sop on byte 0 only; last on byte 258; is_asm on bytes 0–3.
- RAND_EN = 0, two rs_encoder-produced codewords:
  - output is ASM + 255 bytes + ASM + 255 bytes, identical to the input.
  - is_parity set on bytes 227–258 of each frame; frame_err = 0.
- Random m_axis_ready stalls (~87% duty, LFSR seed 32'h1ACEB00C):
  - byte stream identical to the no-stall case.
  - data stable while valid & !ready; no bytes lost or duplicated.
- s_axis_last asserted early at byte 100:
  - frame_err rises after that handshake and stays 1.
  - m_axis_last still appears only at codeword byte 254.
- rst_n pulsed low at codeword byte 50:
  - outputs clear asynchronously.
  - the following clean codeword yields 1A CF FC 1D FF 48 … again.
